// File: rtl/ysyx_220053_idu_stage.sv
// ---------------------------------------------------------------------------
// ysyx_220053_idu_stage
//
// Registered instruction-decode stage sitting between the IFU and the EXU.
// An instruction accepted on the input handshake is decoded combinationally.
// The decoded bundle is captured in an output register that holds its value
// under backpressure. The stage parks itself in HALT once an ebreak bundle
// has been handed to the EXU, and stays there until resume_i is pulsed.
//
// Parameters
//   XLEN   : datapath / immediate width (32 or 64). The RV64 word ops
//            (OP-IMM-32, OP-32) decode as legal only when XLEN == 64.
//   CNT_W  : width of the handed-off bundle counter (wraps).
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : IFU handshake, carrying in_instr_i and in_pc_i
//   out_valid_o/out_ready_i : EXU handshake
//   out_pc_o .. out_ebreak_o : registered decoded bundle
//   flush_i               : drop the held bundle and any concurrent input
//   resume_i              : leave HALT
//   halted_o              : stage is in HALT
//   dec_cnt_o             : number of bundles transferred to the EXU
// ---------------------------------------------------------------------------
module ysyx_220053_idu_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [4:0]       out_rd_o,
    output logic [4:0]       out_rs1_o,
    output logic [4:0]       out_rs2_o,
    output logic [2:0]       out_func3_o,
    output logic [6:0]       out_func7_o,
    output logic [6:0]       out_opcode_o,
    output logic [2:0]       out_fmt_o,
    output logic [XLEN-1:0]  out_imm_o,
    output logic             out_rf_wen_o,
    output logic             out_illegal_o,
    output logic             out_ecall_o,
    output logic             out_ebreak_o,
    input  logic             flush_i,
    input  logic             resume_i,
    output logic             halted_o,
    output logic [CNT_W-1:0] dec_cnt_o
);

    // Major opcodes
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    // Instruction formats as presented on out_fmt_o
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic RV64 = (XLEN == 64);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [31:0]     imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    logic [31:0]     imm32;
    logic [63:0]     imm64;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            dec_ecall;
    logic            dec_ebreak;
    logic            dec_wen_cls;   // opcode class that writes rd
    logic            dec_imm_zero;  // force imm to 0 (undecodable opcode)
    logic            dec_rf_wen;

    assign opcode = in_instr_i[6:0];

    // Every immediate is first built as a 32-bit sign-extended value, then
    // widened to 64 bits and cut down to XLEN; this keeps one code path
    // valid for both XLEN settings.
    assign imm_i32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_s32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
    assign imm_b32 = {{20{in_instr_i[31]}}, in_instr_i[7], in_instr_i[30:25],
                      in_instr_i[11:8], 1'b0};
    assign imm_u32 = {in_instr_i[31:12], 12'b0};
    assign imm_j32 = {{12{in_instr_i[31]}}, in_instr_i[19:12], in_instr_i[20],
                      in_instr_i[30:21], 1'b0};

    always_comb begin
        dec_fmt      = FMT_I;
        dec_illegal  = 1'b0;
        dec_ecall    = 1'b0;
        dec_ebreak   = 1'b0;
        dec_wen_cls  = 1'b0;
        dec_imm_zero = 1'b0;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt     = FMT_U;
                dec_wen_cls = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt     = FMT_J;
                dec_wen_cls = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                dec_fmt     = FMT_I;
                dec_wen_cls = 1'b1;
            end
            OPC_BRANCH: dec_fmt = FMT_B;
            OPC_STORE:  dec_fmt = FMT_S;
            OPC_OP: begin
                dec_fmt     = FMT_R;
                dec_wen_cls = 1'b1;
            end
            OPC_SYSTEM: begin
                // Only the exact ecall/ebreak encodings are supported;
                // CSR ops and everything else under SYSTEM trap.
                dec_fmt = FMT_I;
                if (in_instr_i == INSTR_ECALL) begin
                    dec_ecall = 1'b1;
                end else if (in_instr_i == INSTR_EBREAK) begin
                    dec_ebreak = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OPIMM32: begin
                if (RV64) begin
                    dec_fmt     = FMT_I;
                    dec_wen_cls = 1'b1;
                end else begin
                    dec_illegal  = 1'b1;
                    dec_imm_zero = 1'b1;
                end
            end
            OPC_OP32: begin
                if (RV64) begin
                    dec_fmt     = FMT_R;
                    dec_wen_cls = 1'b1;
                end else begin
                    dec_illegal  = 1'b1;
                    dec_imm_zero = 1'b1;
                end
            end
            default: begin
                dec_illegal  = 1'b1;
                dec_imm_zero = 1'b1;
            end
        endcase
    end

    always_comb begin
        imm32 = 32'h0;
        unique case (dec_fmt)
            FMT_I:   imm32 = imm_i32;
            FMT_S:   imm32 = imm_s32;
            FMT_B:   imm32 = imm_b32;
            FMT_U:   imm32 = imm_u32;
            FMT_J:   imm32 = imm_j32;
            default: imm32 = 32'h0;
        endcase
        if (dec_imm_zero) begin
            imm32 = 32'h0;
        end
    end

    assign imm64      = {{32{imm32[31]}}, imm32};
    assign dec_imm    = imm64[XLEN-1:0];
    assign dec_rf_wen = dec_wen_cls & (in_instr_i[11:7] != 5'd0) & ~dec_illegal;

    // ------------------------------------------------------------------
    // Handshake / control
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic            xfer;
    logic            accept;
    logic            load;

    logic [XLEN-1:0] out_pc_q;
    logic [4:0]      out_rd_q, out_rs1_q, out_rs2_q;
    logic [2:0]      out_func3_q;
    logic [6:0]      out_func7_q, out_opcode_q;
    logic [2:0]      out_fmt_q;
    logic [XLEN-1:0] out_imm_q;
    logic            out_rf_wen_q, out_illegal_q, out_ecall_q, out_ebreak_q;

    assign xfer       = out_valid_q & out_ready_i;
    assign in_ready_o = (state_q == S_RUN) & (~out_valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    // A beat accepted under flush is consumed but never captured.
    assign load       = accept & ~flush_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an ebreak leaving the stage wins over a concurrent resume,
    // so the stage always halts behind an ebreak even under flush.
    always_comb begin
        state_d = state_q;
        if (xfer && out_ebreak_q) begin
            state_d = S_HALT;
        end else if ((state_q == S_HALT) && resume_i) begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;   // covers reload-while-transferring
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    assign dec_cnt_d = dec_cnt_q + CNT_W'(xfer);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q   <= 1'b0;
            dec_cnt_q     <= '0;
            out_pc_q      <= '0;
            out_rd_q      <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_func3_q   <= '0;
            out_func7_q   <= '0;
            out_opcode_q  <= '0;
            out_fmt_q     <= '0;
            out_imm_q     <= '0;
            out_rf_wen_q  <= 1'b0;
            out_illegal_q <= 1'b0;
            out_ecall_q   <= 1'b0;
            out_ebreak_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dec_cnt_q   <= dec_cnt_d;
            if (load) begin
                out_pc_q      <= in_pc_i;
                out_rd_q      <= in_instr_i[11:7];
                out_rs1_q     <= in_instr_i[19:15];
                out_rs2_q     <= in_instr_i[24:20];
                out_func3_q   <= in_instr_i[14:12];
                out_func7_q   <= in_instr_i[31:25];
                out_opcode_q  <= in_instr_i[6:0];
                out_fmt_q     <= dec_fmt;
                out_imm_q     <= dec_imm;
                out_rf_wen_q  <= dec_rf_wen;
                out_illegal_q <= dec_illegal;
                out_ecall_q   <= dec_ecall;
                out_ebreak_q  <= dec_ebreak;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = out_pc_q;
    assign out_rd_o      = out_rd_q;
    assign out_rs1_o     = out_rs1_q;
    assign out_rs2_o     = out_rs2_q;
    assign out_func3_o   = out_func3_q;
    assign out_func7_o   = out_func7_q;
    assign out_opcode_o  = out_opcode_q;
    assign out_fmt_o     = out_fmt_q;
    assign out_imm_o     = out_imm_q;
    assign out_rf_wen_o  = out_rf_wen_q;
    assign out_illegal_o = out_illegal_q;
    assign out_ecall_o   = out_ecall_q;
    assign out_ebreak_o  = out_ebreak_q;
    assign halted_o      = (state_q == S_HALT);
    assign dec_cnt_o     = dec_cnt_q;

endmodule

// File: tb/tb_ysyx_220053_idu_stage.sv
module tb_ysyx_220053_idu_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic        rst, in_valid, in_ready, out_valid, out_ready, flush, resume, halted;
    logic [31:0] in_instr;
    logic [63:0] in_pc, out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_func3, out_fmt;
    logic [6:0]  out_func7, out_opcode;
    logic        out_rf_wen, out_illegal, out_ecall, out_ebreak;
    logic [31:0] dec_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_halted;
    logic [31:0] s_in_instr, s_in_pc, s_out_pc, s_out_imm;
    logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
    logic [2:0]  s_out_func3, s_out_fmt;
    logic [6:0]  s_out_func7, s_out_opcode;
    logic        s_out_rf_wen, s_out_illegal, s_out_ecall, s_out_ebreak;
    logic [1:0]  s_dec_cnt;
    logic        s_one = 1'b1;
    logic        s_zero = 1'b0;

    ysyx_220053_idu_stage #(.XLEN(64), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_rd_o(out_rd), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2),
        .out_func3_o(out_func3), .out_func7_o(out_func7), .out_opcode_o(out_opcode),
        .out_fmt_o(out_fmt), .out_imm_o(out_imm), .out_rf_wen_o(out_rf_wen),
        .out_illegal_o(out_illegal), .out_ecall_o(out_ecall), .out_ebreak_o(out_ebreak),
        .flush_i(flush), .resume_i(resume), .halted_o(halted), .dec_cnt_o(dec_cnt)
    );

    ysyx_220053_idu_stage #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .in_instr_i(s_in_instr), .in_pc_i(s_in_pc),
        .out_valid_o(s_out_valid), .out_ready_i(s_one),
        .out_pc_o(s_out_pc), .out_rd_o(s_out_rd), .out_rs1_o(s_out_rs1), .out_rs2_o(s_out_rs2),
        .out_func3_o(s_out_func3), .out_func7_o(s_out_func7), .out_opcode_o(s_out_opcode),
        .out_fmt_o(s_out_fmt), .out_imm_o(s_out_imm), .out_rf_wen_o(s_out_rf_wen),
        .out_illegal_o(s_out_illegal), .out_ecall_o(s_out_ecall), .out_ebreak_o(s_out_ebreak),
        .flush_i(s_zero), .resume_i(s_zero), .halted_o(s_halted), .dec_cnt_o(s_dec_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        wen, ill, ec, eb;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    logic        m_valid, m_halt;
    logic [31:0] m_cnt;

    task automatic set_in(input logic [31:0] ins, input logic [63:0] pc, input logic [2:0] fmt,
                          input logic [63:0] imm, input logic wen, input logic ill,
                          input logic ec, input logic eb);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        cur.instr = ins;
        cur.pc    = pc;
        cur.fmt   = fmt;
        cur.imm   = imm;
        cur.wen   = wen;
        cur.ill   = ill;
        cur.ec    = ec;
        cur.eb    = eb;
    endtask

    task automatic cyc();
        exp_t h;
        logic rdy, acc, xf, eb;
        @(negedge clk);
        rdy = !m_halt && (!m_valid || out_ready);
        chk("in_ready", in_ready, rdy);
        chk("halted", halted, m_halt);
        chk("dec_cnt", dec_cnt, m_cnt);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("sb_nonempty", (q.size() > 0), 1'b1);
            if (q.size() > 0) begin
                h = q[0];
                chk("out_pc", out_pc, h.pc);
                chk("out_rd", out_rd, h.instr[11:7]);
                chk("out_rs1", out_rs1, h.instr[19:15]);
                chk("out_rs2", out_rs2, h.instr[24:20]);
                chk("out_func3", out_func3, h.instr[14:12]);
                chk("out_func7", out_func7, h.instr[31:25]);
                chk("out_opcode", out_opcode, h.instr[6:0]);
                chk("out_fmt", out_fmt, h.fmt);
                chk("out_imm", out_imm, h.imm);
                chk("out_rf_wen", out_rf_wen, h.wen);
                chk("out_illegal", out_illegal, h.ill);
                chk("out_ecall", out_ecall, h.ec);
                chk("out_ebreak", out_ebreak, h.eb);
            end
        end
        acc = in_valid && rdy;
        xf  = m_valid && out_ready;
        if (rst) begin
            m_valid = 1'b0;
            m_halt  = 1'b0;
            m_cnt   = 32'd0;
            q.delete();
        end else begin
            eb = 1'b0;
            if (xf && q.size() > 0) begin
                eb = q[0].eb;
                void'(q.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (xf && eb) m_halt = 1'b1;
            else if (m_halt && resume) m_halt = 1'b0;
            if (flush) begin
                m_valid = 1'b0;
                q.delete();
            end else if (acc) begin
                q.push_back(cur);
                m_valid = 1'b1;
            end else if (xf) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] PC0    = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 64'h0;
        out_ready = 1'b0; flush = 1'b0; resume = 1'b0;
        s_in_valid = 1'b0; s_in_instr = 32'h0; s_in_pc = 32'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'd0;
        cur.instr = 32'h0; cur.pc = 64'h0; cur.fmt = 3'd0; cur.imm = 64'h0;
        cur.wen = 1'b0; cur.ill = 1'b0; cur.ec = 1'b0; cur.eb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_imm", out_imm, 64'h0);
        chk("rst_out_fmt", out_fmt, 3'd0);
        chk("rst_out_opcode", out_opcode, 7'd0);
        chk("rst_out_rf_wen", out_rf_wen, 1'b0);
        chk("rst_s_dec_cnt", s_dec_cnt, 2'd0);

        resume = 1'b1; cyc(); resume = 1'b0;

        out_ready = 1'b1;
        set_in(32'hFFF00093, PC0,        3'd1, ONES,                   1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(32'h0020A423, PC0 + 64'd4, 3'd2, 64'd8,                 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(32'hFE000EE3, PC0 + 64'd8, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        in_valid = 1'b0; cyc(); cyc();

        out_ready = 1'b0;
        set_in(32'h123452B7, PC0 + 64'd12, 3'd4, 64'h0000_0000_1234_5000, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(32'h8000006F, PC0 + 64'd16, 3'd5, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc(); cyc();
        out_ready = 1'b1; cyc();
        set_in(32'h002081B3, PC0 + 64'd20, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(32'h0010009B, PC0 + 64'd24, 3'd1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(32'h00000000, PC0 + 64'd28, 3'd1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0); cyc();
        set_in(32'h00000073, PC0 + 64'd32, 3'd1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
        in_valid = 1'b0; cyc(); cyc();

        set_in(32'h00100073, PC0 + 64'd36, 3'd1, 64'h1, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        in_valid = 1'b0; cyc();
        set_in(32'hFFF00093, PC0 + 64'd40, 3'd1, ONES, 1'b1, 1'b0, 1'b0, 1'b0); cyc(); cyc();
        resume = 1'b1; cyc();
        resume = 1'b0; cyc();
        in_valid = 1'b0; cyc(); cyc();

        set_in(32'h00100073, PC0 + 64'd44, 3'd1, 64'h1, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        in_valid = 1'b0; resume = 1'b1; cyc();
        resume = 1'b0; cyc();
        resume = 1'b1; cyc();
        resume = 1'b0; cyc();

        out_ready = 1'b0;
        set_in(32'hFFF00093, PC0 + 64'd48, 3'd1, ONES, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(32'h002081B3, PC0 + 64'd52, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0); flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0; cyc();
        set_in(32'h123452B7, PC0 + 64'd56, 3'd4, 64'h0000_0000_1234_5000, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0; cyc();
        out_ready = 1'b1;
        set_in(32'h8000006F, PC0 + 64'd60, 3'd5, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(32'h002081B3, PC0 + 64'd64, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0); flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0; cyc(); cyc();
        set_in(32'h00100073, PC0 + 64'd68, 3'd1, 64'h1, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        in_valid = 1'b0; flush = 1'b1; cyc();
        flush = 1'b0; cyc();

        set_in(32'hFFF00093, PC0 + 64'd72, 3'd1, ONES, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst2_out_imm", out_imm, 64'h0);
        chk("rst2_out_ebreak", out_ebreak, 1'b0);
        chk("rst2_out_pc", out_pc, 64'h0);
        cyc();

        s_in_valid = 1'b1; s_in_instr = 32'h0010009B; s_in_pc = 32'h100;
        @(posedge clk); #1;
        s_in_instr = 32'hFFF00093; s_in_pc = 32'h104;
        @(negedge clk);
        chk("rv32_valid", s_out_valid, 1'b1);
        chk("rv32_addiw_illegal", s_out_illegal, 1'b1);
        chk("rv32_addiw_wen", s_out_rf_wen, 1'b0);
        chk("rv32_addiw_fmt", s_out_fmt, 3'd1);
        chk("rv32_addiw_imm", s_out_imm, 32'h0);
        chk("rv32_addiw_pc", s_out_pc, 32'h100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rv32_addi_illegal", s_out_illegal, 1'b0);
        chk("rv32_addi_wen", s_out_rf_wen, 1'b1);
        chk("rv32_addi_imm", s_out_imm, 32'hFFFF_FFFF);
        chk("rv32_cnt1", s_dec_cnt, 2'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        chk("rv32_cnt_wrap0", s_dec_cnt, 2'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rv32_cnt_wrap1", s_dec_cnt, 2'd1);
        chk("rv32_drained", s_out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
